// File: rtl/hls_macc_pkg.sv
// Shared types for the hls_macc run controller.
//   run_state_t : sequencer states around one core run
//   res_rec_t   : one result record as stored in the result FIFO
//   MASK_*      : bit positions of each core output in the record mask
package hls_macc_pkg;

  localparam int MACC_DATA_W = 32;

  localparam int MASK_OUT13 = 0;
  localparam int MASK_OUT30 = 1;
  localparam int MASK_OUT31 = 2;
  localparam int MASK_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PUSH  = 2'd3
  } run_state_t;

  typedef struct packed {
    logic [MACC_DATA_W-1:0] out13;
    logic [MACC_DATA_W-1:0] out30;
    logic [MACC_DATA_W-1:0] out31;
    logic [MASK_W-1:0]      mask;
    logic                   timeout;
  } res_rec_t;

endpackage

// File: rtl/hls_macc_run_ctrl_if.sv
// Bundle of the hls_macc core's ap_ctrl_hs handshake and ap_vld data ports.
//   master : run controller side (drives ap_start and the out30_i feedback)
//   slave  : core side (drives ready/done/idle and the vld-qualified results)
interface hls_macc_run_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic [DATA_W-1:0] out13;
  logic              out13_vld;
  logic [DATA_W-1:0] out30_o;
  logic              out30_vld;
  logic [DATA_W-1:0] out31;
  logic              out31_vld;
  logic [DATA_W-1:0] out30_i;

  modport master (
    output ap_start, out30_i,
    input  ap_ready, ap_done, ap_idle,
    input  out13, out13_vld, out30_o, out30_vld, out31, out31_vld
  );

  modport slave (
    input  ap_start, out30_i,
    output ap_ready, ap_done, ap_idle,
    output out13, out13_vld, out30_o, out30_vld, out31, out31_vld
  );

endinterface

// File: rtl/hls_macc_res_fifo.sv
// Synchronous FIFO of result records.
//   clk, srst      : clock, synchronous active-high reset
//   push, push_rec : write one record (ignored when full)
//   pop            : drop the head record (ignored when empty)
//   head_rec       : current head, combinational read
//   valid          : FIFO holds at least one record
//   level          : number of records held
module hls_macc_res_fifo
  import hls_macc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push,
  input  res_rec_t               push_rec,
  input  logic                   pop,
  output res_rec_t               head_rec,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  res_rec_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic                 do_push;
  logic                 do_pop;

  assign valid   = (level_reg != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (level_reg != LVL_W'(DEPTH));

  // Storage is not reset; the head is only meaningful while valid is high.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_rec;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head_rec = mem[rd_ptr_reg];
  assign level    = level_reg;

endmodule

// File: rtl/hls_macc_run_ctrl.sv
// Run sequencer and result capture around the hls_macc core.
//   ap_clk, ap_rst : clock, synchronous active-high reset (same net as the core's ap_rst)
//   req_valid/req_ready : one run request per handshake
//   acc_clear      : reload the out30 feedback register with ACC_INIT while idle
//   core           : core handshake and data ports (master side)
//   res_*          : head record of the result FIFO, popped with res_valid && res_ready
//   fifo_level     : records held in the result FIFO
//   busy           : a run is in progress
module hls_macc_run_ctrl
  import hls_macc_pkg::*;
#(
  parameter int                DATA_W      = MACC_DATA_W,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] ACC_INIT    = '0,
  parameter int                TIMEOUT_CYC = 256
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        acc_clear,
  hls_macc_run_ctrl_if.master         core,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_W-1:0]           res_out13,
  output logic [DATA_W-1:0]           res_out30,
  output logic [DATA_W-1:0]           res_out31,
  output logic [2:0]                  res_mask,
  output logic                        res_timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  run_state_t        state_reg, state_next;
  logic [WD_W-1:0]   wd_cnt_reg;
  logic              timeout_reg;
  logic [DATA_W-1:0] acc_reg;

  logic              in_run;
  logic              accept;
  logic              push;
  logic              timeout_set;
  logic              wd_expired;
  logic              fifo_space;

  logic [MASK_W-1:0] cap_vld;
  logic [DATA_W-1:0] cap_din  [MASK_W];
  logic [DATA_W-1:0] cap_data [MASK_W];
  logic [MASK_W-1:0] mask_vec;

  res_rec_t          push_rec;
  res_rec_t          head_rec;

  assign in_run     = (state_reg == ST_START) || (state_reg == ST_WAIT);
  assign fifo_space = (fifo_level < LVL_W'(FIFO_DEPTH));
  // Counter value k-1 during the k-th run cycle, so expiry lands on cycle TIMEOUT_CYC.
  assign wd_expired = (TIMEOUT_CYC != 0) && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    core.ap_start = 1'b0;
    accept        = 1'b0;
    push          = 1'b0;
    timeout_set   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // acc_clear wins over a request in the same cycle by withholding ready.
        req_ready = !ap_rst && !acc_clear && fifo_space;
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        core.ap_start = 1'b1;
        if (core.ap_ready && core.ap_done) begin
          state_next = ST_PUSH;
        end else if (wd_expired) begin
          timeout_set = 1'b1;
          state_next  = ST_PUSH;
        end else if (core.ap_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core.ap_done) begin
          state_next = ST_PUSH;
        end else if (wd_expired) begin
          timeout_set = 1'b1;
          state_next  = ST_PUSH;
        end
      end
      ST_PUSH: begin
        push       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Watchdog, timeout flag and out30 feedback register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
      acc_reg     <= ACC_INIT;
    end else begin
      if (accept) begin
        wd_cnt_reg  <= '0;
        timeout_reg <= 1'b0;
      end else if (in_run) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (timeout_set) begin
        timeout_reg <= 1'b1;
      end
      if ((state_reg == ST_IDLE) && acc_clear) begin
        acc_reg <= ACC_INIT;
      end else if (in_run && core.out30_vld) begin
        acc_reg <= core.out30_o;
      end
    end
  end

  assign core.out30_i = acc_reg;

  assign cap_vld[MASK_OUT13] = core.out13_vld;
  assign cap_vld[MASK_OUT30] = core.out30_vld;
  assign cap_vld[MASK_OUT31] = core.out31_vld;
  assign cap_din[MASK_OUT13] = core.out13;
  assign cap_din[MASK_OUT30] = core.out30_o;
  assign cap_din[MASK_OUT31] = core.out31;

  // One capture register plus mask bit per core output; the last strobe in a run wins.
  for (genvar gi = 0; gi < MASK_W; gi++) begin : g_cap
    logic [DATA_W-1:0] data_reg;
    logic              hit_reg;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        data_reg <= '0;
        hit_reg  <= 1'b0;
      end else if (accept) begin
        data_reg <= '0;
        hit_reg  <= 1'b0;
      end else if (in_run && cap_vld[gi]) begin
        data_reg <= cap_din[gi];
        hit_reg  <= 1'b1;
      end
    end

    assign cap_data[gi] = data_reg;
    assign mask_vec[gi] = hit_reg;
  end

  always_comb begin
    push_rec         = '0;
    push_rec.out13   = MACC_DATA_W'(cap_data[MASK_OUT13]);
    push_rec.out30   = MACC_DATA_W'(cap_data[MASK_OUT30]);
    push_rec.out31   = MACC_DATA_W'(cap_data[MASK_OUT31]);
    push_rec.mask    = mask_vec;
    push_rec.timeout = timeout_reg;
  end

  hls_macc_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk      (ap_clk),
    .srst     (ap_rst),
    .push     (push),
    .push_rec (push_rec),
    .pop      (res_ready),
    .head_rec (head_rec),
    .valid    (res_valid),
    .level    (fifo_level)
  );

  // Head fields read as zero while empty so the port is clean after reset.
  assign res_out13   = res_valid ? DATA_W'(head_rec.out13) : '0;
  assign res_out30   = res_valid ? DATA_W'(head_rec.out30) : '0;
  assign res_out31   = res_valid ? DATA_W'(head_rec.out31) : '0;
  assign res_mask    = res_valid ? head_rec.mask : '0;
  assign res_timeout = res_valid && head_rec.timeout;
  assign busy        = (state_reg != ST_IDLE);

endmodule
